// File: rtl/triangle_channel_if.sv
// rtl/triangle_channel_if.sv - CPU register write bus for the APU triangle voice
interface triangle_channel_if;
    logic       reg_wr;
    logic [1:0] reg_addr;
    logic [7:0] reg_data;

    modport master (
        output reg_wr,
        output reg_addr,
        output reg_data
    );

    modport slave (
        input reg_wr,
        input reg_addr,
        input reg_data
    );
endinterface

// File: rtl/triangle_channel.sv
// rtl/triangle_channel.sv - NES APU triangle voice: timer, linear/length counters, 32-step sequencer
module triangle_channel #(
    parameter int TIMER_W    = 11,
    parameter int MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_tick,
    input  logic                quarter_frame,
    input  logic                half_frame,
    input  logic                enable,
    triangle_channel_if.slave   bus,
    output logic                length_active,
    output logic [3:0]          tr_out
);

    logic               ctrl_flag;
    logic [6:0]         lin_reload_val;
    logic [TIMER_W-1:0] period;
    logic [TIMER_W-1:0] timer;
    logic [6:0]         linear;
    logic [7:0]         length;
    logic               reload_flag;
    logic [4:0]         step;
    logic               step_moved;

    logic wr_4008;
    logic wr_400a;
    logic wr_400b;
    logic step_en;

    // Length counter load values indexed by $400B d[7:3]
    function automatic logic [7:0] len_tbl(input logic [4:0] idx);
        case (idx)
            5'd0:  len_tbl = 8'd10;
            5'd1:  len_tbl = 8'd254;
            5'd2:  len_tbl = 8'd20;
            5'd3:  len_tbl = 8'd2;
            5'd4:  len_tbl = 8'd40;
            5'd5:  len_tbl = 8'd4;
            5'd6:  len_tbl = 8'd80;
            5'd7:  len_tbl = 8'd6;
            5'd8:  len_tbl = 8'd160;
            5'd9:  len_tbl = 8'd8;
            5'd10: len_tbl = 8'd60;
            5'd11: len_tbl = 8'd10;
            5'd12: len_tbl = 8'd14;
            5'd13: len_tbl = 8'd12;
            5'd14: len_tbl = 8'd26;
            5'd15: len_tbl = 8'd14;
            5'd16: len_tbl = 8'd12;
            5'd17: len_tbl = 8'd16;
            5'd18: len_tbl = 8'd24;
            5'd19: len_tbl = 8'd18;
            5'd20: len_tbl = 8'd48;
            5'd21: len_tbl = 8'd20;
            5'd22: len_tbl = 8'd96;
            5'd23: len_tbl = 8'd22;
            5'd24: len_tbl = 8'd192;
            5'd25: len_tbl = 8'd24;
            5'd26: len_tbl = 8'd72;
            5'd27: len_tbl = 8'd26;
            5'd28: len_tbl = 8'd16;
            5'd29: len_tbl = 8'd28;
            5'd30: len_tbl = 8'd32;
            default: len_tbl = 8'd30;
        endcase
    endfunction

    // Triangle shape: 15 down to 0 over the first half, 0 up to 15 over the second
    function automatic logic [3:0] tri_level(input logic [4:0] s);
        tri_level = s[4] ? s[3:0] : ~s[3:0];
    endfunction

    assign wr_4008 = bus.reg_wr && (bus.reg_addr == 2'd0);
    assign wr_400a = bus.reg_wr && (bus.reg_addr == 2'd2);
    assign wr_400b = bus.reg_wr && (bus.reg_addr == 2'd3);

    // Sequencer only moves when both counters are live and the pitch is audible
    assign step_en = (linear != 7'd0) && (length != 8'd0) &&
                     (period >= TIMER_W'(MIN_PERIOD));

    assign length_active = (length != 8'd0);

    // Control register and period latches written from the CPU bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_flag      <= 1'b0;
            lin_reload_val <= 7'd0;
            period         <= '0;
        end else begin
            if (wr_4008) begin
                ctrl_flag      <= bus.reg_data[7];
                lin_reload_val <= bus.reg_data[6:0];
            end
            if (wr_400a) begin
                period[7:0] <= bus.reg_data;
            end
            if (wr_400b) begin
                period[TIMER_W-1:8] <= bus.reg_data[TIMER_W-9:0];
            end
        end
    end

    // Timer divider and sequencer step, both advanced only on CPU cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            step       <= 5'd0;
            step_moved <= 1'b0;
        end else begin
            step_moved <= 1'b0;
            if (cpu_tick) begin
                if (timer == '0) begin
                    timer <= period;
                    if (step_en) begin
                        step       <= step + 5'd1;
                        step_moved <= 1'b1;
                    end
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

    // Output level follows the step one clk late and holds while the sequencer is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tr_out <= 4'd0;
        end else if (step_moved) begin
            tr_out <= tri_level(step);
        end
    end

    // Linear counter and its reload flag; a $400B write outranks the flag clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            linear      <= 7'd0;
            reload_flag <= 1'b0;
        end else begin
            if (quarter_frame) begin
                if (reload_flag) begin
                    linear <= lin_reload_val;
                end else if (linear != 7'd0) begin
                    linear <= linear - 7'd1;
                end
                if (!ctrl_flag) begin
                    reload_flag <= 1'b0;
                end
            end
            if (wr_400b) begin
                reload_flag <= 1'b1;
            end
        end
    end

    // Length counter: disable clears, then load, then half-frame decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length <= 8'd0;
        end else if (!enable) begin
            length <= 8'd0;
        end else if (wr_400b) begin
            length <= len_tbl(bus.reg_data[7:3]);
        end else if (half_frame && (length != 8'd0) && !ctrl_flag) begin
            length <= length - 8'd1;
        end
    end

endmodule

// File: tb/tb_triangle_channel.sv
// tb/tb_triangle_channel.sv - directed self-checking bench for triangle_channel
module tb_triangle_channel;

    logic       clk;
    logic       rst;
    logic       cpu_tick;
    logic       quarter_frame;
    logic       half_frame;
    logic       enable;
    logic       length_active;
    logic [3:0] tr_out;

    int n_checks;
    int n_fail;

    triangle_channel_if bus ();

    triangle_channel dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_tick      (cpu_tick),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .enable        (enable),
        .bus           (bus.slave),
        .length_active (length_active),
        .tr_out        (tr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand formula for the triangle level of a given step
    function automatic int exp_level(input int s);
        int m;
        m = s % 32;
        exp_level = (m < 16) ? (15 - m) : (m - 16);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        bus.reg_wr   = 1'b1;
        bus.reg_addr = addr;
        bus.reg_data = data;
        step_clk();
        bus.reg_wr   = 1'b0;
    endtask

    task automatic tick(input int n);
        cpu_tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        cpu_tick = 1'b0;
    endtask

    task automatic qf();
        quarter_frame = 1'b1;
        step_clk();
        quarter_frame = 1'b0;
    endtask

    task automatic hf();
        half_frame = 1'b1;
        step_clk();
        half_frame = 1'b0;
    endtask

    // Global watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        cpu_tick      = 1'b0;
        quarter_frame = 1'b0;
        half_frame    = 1'b0;
        enable        = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_data  = 8'd0;
        #12;
        check("reset_tr_out", tr_out, 0);
        check("reset_len_active", length_active, 0);
        step_clk();
        rst = 1'b0;

        // Idle after reset: nothing moves
        tick(100);
        check("idle_tr_out", tr_out, 0);
        check("idle_len_active", length_active, 0);

        // Full waveform with ctrl_flag=1, period 4 -> one step per 5 ticks
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h04);
        wr(2'd3, 8'h08);
        check("len254_active", length_active, 1);
        qf();
        tick(2);
        check("seq_step1", tr_out, 14);
        for (int k = 2; k <= 40; k++) begin
            tick(5);
            check($sformatf("seq_step%0d", k), tr_out, exp_level(k));
        end

        // ctrl_flag=0: linear counts to 0 and the sequencer freezes holding its level
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h04);
        wr(2'd3, 8'h08);
        qf();
        tick(2);
        check("lin_step1", tr_out, 14);
        tick(5);
        check("lin_step2", tr_out, 13);
        qf();
        tick(50);
        check("lin_frozen_hold", tr_out, 13);

        // Length counter countdown and enable gating
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h18);
        check("len2_active", length_active, 1);
        hf();
        check("len1_active", length_active, 1);
        hf();
        check("len0_active", length_active, 0);
        enable = 1'b0;
        wr(2'd3, 8'h18);
        check("len_disabled_load", length_active, 0);
        enable = 1'b1;
        wr(2'd3, 8'h08);
        check("len_enabled_load", length_active, 1);
        enable = 1'b0;
        step_clk();
        check("len_enable_clear", length_active, 0);

        // Ultrasonic period freezes the sequencer; an audible period resumes it
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h08);
        qf();
        tick(50);
        check("period1_frozen", tr_out, 0);
        wr(2'd2, 8'h03);
        tick(2);
        check("period3_step1", tr_out, 14);
        tick(4);
        check("period3_step2", tr_out, 13);
        tick(4);
        check("period3_step3", tr_out, 12);

        // Same-clk $400B load and half_frame: load wins, undecremented
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h18);
        half_frame = 1'b1;
        wr(2'd3, 8'h00);
        half_frame = 1'b0;
        repeat (9) hf();
        check("len10_after9", length_active, 1);
        hf();
        check("len10_after10", length_active, 0);

        // Same-clk quarter_frame and $400B write leaves reload_flag set
        do_reset();
        enable = 1'b1;
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h04);
        wr(2'd3, 8'h08);
        qf();
        qf();
        tick(20);
        check("reload_linear0", tr_out, 0);
        quarter_frame = 1'b1;
        wr(2'd3, 8'h08);
        quarter_frame = 1'b0;
        qf();
        tick(2);
        check("reload_flag_kept", tr_out, 14);

        // Asynchronous reset mid-sequence clears outputs without a clock edge
        tick(3);
        rst = 1'b1;
        #1;
        check("midrst_tr_out", tr_out, 0);
        check("midrst_len_active", length_active, 0);
        step_clk();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
